reg_file_raddr_scoreboard: RTL and testbench

Read-side companion to the register-file write-address/enable controller. Sits in decode and tracks destination registers of issued, not-yet-retired instructions in per-register pending counters. Stalls decode when a used source operand (rs/rt) has a write outstanding, and releases the stall once writeback retires that register. Drives the register-file read addresses and an issue strobe to the downstream pipeline.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/reg_pending_counter.sv | 31 +++
 rtl/reg_file_raddr_scoreboard.sv | 95 +++++++++
 tb/tb_reg_file_raddr_scoreboard.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and counter width helper
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Bits needed to hold 0..max_inflight outstanding writes
  function automatic int cnt_width(input int max_inflight);
    return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/reg_pending_counter.sv
// rtl/reg_pending_counter.sv - outstanding-write counter for one architectural register
module reg_pending_counter
  import regfile_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = cnt_width(MAX_INFLIGHT)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             full
);

  // Issue and retire in the same cycle cancel; the caller only raises dec when nonzero
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      count <= count - CNT_W'(1);
    end
  end

  assign nonzero = (count != '0);
  assign full    = (count == CNT_W'(MAX_INFLIGHT));

endmodule

// File: rtl/reg_file_raddr_scoreboard.sv
// rtl/reg_file_raddr_scoreboard.sv - decode-side scoreboard driving read addresses, stall and issue
module reg_file_raddr_scoreboard
  import regfile_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  w_dec_valid,
  input  logic [REG_ADDR_W-1:0] w_rs,
  input  logic [REG_ADDR_W-1:0] w_rt,
  input  logic                  w_rs_used,
  input  logic                  w_rt_used,
  input  logic                  w_dec_wen,
  input  logic [REG_ADDR_W-1:0] w_dec_waddr,
  input  logic                  w_wb_en,
  input  logic [REG_ADDR_W-1:0] w_wb_addr,
  output logic [REG_ADDR_W-1:0] w_raddr_a,
  output logic [REG_ADDR_W-1:0] w_raddr_b,
  output logic                  w_stall,
  output logic                  w_issue,
  output logic                  w_busy_any,
  output logic                  w_err
);

  localparam int CNT_W = cnt_width(MAX_INFLIGHT);

  logic [CNT_W-1:0] pend [1:NREGS-1];
  logic [NREGS-1:0] pend_nz;
  logic [NREGS-1:0] pend_full;
  logic             haz_a;
  logic             haz_b;
  logic             haz_full;
  logic             underflow;
  logic             err_q;

  // Register 0 is hardwired and never tracked
  assign pend_nz[0]   = 1'b0;
  assign pend_full[0] = 1'b0;

  genvar g;
  generate
    for (g = 1; g < NREGS; g++) begin : g_pend
      logic inc;
      logic dec;
      assign inc = w_issue && w_dec_wen && (w_dec_waddr == REG_ADDR_W'(g));
      assign dec = w_wb_en && (w_wb_addr == REG_ADDR_W'(g)) && pend_nz[g];
      reg_pending_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
      ) u_cnt (
        .clock   (clock),
        .reset   (reset),
        .inc     (inc),
        .dec     (dec),
        .count   (pend[g]),
        .nonzero (pend_nz[g]),
        .full    (pend_full[g])
      );
    end
  endgenerate

  assign w_raddr_a = w_rs;
  assign w_raddr_b = w_rt;

  // Hazards look only at registered counters, so writeback never reaches stall combinationally
  assign haz_a    = w_rs_used && (w_rs != REG_ZERO) && pend_nz[w_rs];
  assign haz_b    = w_rt_used && (w_rt != REG_ZERO) && pend_nz[w_rt];
  assign haz_full = w_dec_wen && (w_dec_waddr != REG_ZERO) && pend_full[w_dec_waddr];

  assign w_stall = w_dec_valid && (haz_a || haz_b || haz_full);
  assign w_issue = w_dec_valid && !w_stall;

  // Any outstanding write anywhere in the register file
  always_comb begin
    w_busy_any = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      w_busy_any = w_busy_any | (|pend[r]);
    end
  end

  assign underflow = w_wb_en && (w_wb_addr != REG_ZERO) && !pend_nz[w_wb_addr];

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (underflow) begin
      err_q <= 1'b1;
    end
  end

  assign w_err = err_q;

endmodule

// File: tb/tb_reg_file_raddr_scoreboard.sv
// tb/tb_reg_file_raddr_scoreboard.sv - directed self-checking bench for the read-side scoreboard
module tb_reg_file_raddr_scoreboard;

  logic       clock = 1'b0;
  logic       reset;
  logic       w_dec_valid;
  logic [4:0] w_rs, w_rt;
  logic       w_rs_used, w_rt_used;
  logic       w_dec_wen;
  logic [4:0] w_dec_waddr;
  logic       w_wb_en;
  logic [4:0] w_wb_addr;
  logic [4:0] w_raddr_a, w_raddr_b;
  logic       w_stall, w_issue, w_busy_any, w_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  reg_file_raddr_scoreboard #(.MAX_INFLIGHT(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .w_dec_valid (w_dec_valid),
    .w_rs        (w_rs),
    .w_rt        (w_rt),
    .w_rs_used   (w_rs_used),
    .w_rt_used   (w_rt_used),
    .w_dec_wen   (w_dec_wen),
    .w_dec_waddr (w_dec_waddr),
    .w_wb_en     (w_wb_en),
    .w_wb_addr   (w_wb_addr),
    .w_raddr_a   (w_raddr_a),
    .w_raddr_b   (w_raddr_b),
    .w_stall     (w_stall),
    .w_issue     (w_issue),
    .w_busy_any  (w_busy_any),
    .w_err       (w_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    w_dec_valid = 1'b0;
    w_rs = 5'd0;      w_rt = 5'd0;
    w_rs_used = 1'b0; w_rt_used = 1'b0;
    w_dec_wen = 1'b0; w_dec_waddr = 5'd0;
    w_wb_en = 1'b0;   w_wb_addr = 5'd0;
  endtask

  task automatic issue_wr(input logic [4:0] addr);
    idle();
    w_dec_valid = 1'b1; w_dec_wen = 1'b1; w_dec_waddr = addr;
  endtask

  initial begin
    idle();
    // Reset with a valid instruction reading r5
    reset = 1'b1;
    w_dec_valid = 1'b1; w_rs = 5'd5; w_rs_used = 1'b1;
    step();
    step();
    settle();
    check("rst_stall", w_stall, 0);
    check("rst_issue", w_issue, 1);
    check("rst_busy", w_busy_any, 0);
    check("rst_err", w_err, 0);
    reset = 1'b0;

    // RAW stall on r8
    issue_wr(5'd8);
    settle();
    check("raw_issue_c0", w_issue, 1);
    step();
    idle();
    w_dec_valid = 1'b1; w_rs = 5'd8; w_rs_used = 1'b1; w_rt = 5'd17;
    settle();
    check("raw_stall_c1", w_stall, 1);
    check("raw_issue_c1", w_issue, 0);
    check("raw_raddr_a_c1", w_raddr_a, 8);
    check("raw_raddr_b_c1", w_raddr_b, 17);
    check("raw_busy_c1", w_busy_any, 1);
    step();
    check("raw_stall_c2", w_stall, 1);
    step();
    w_wb_en = 1'b1; w_wb_addr = 5'd8;
    settle();
    check("raw_stall_c3", w_stall, 1);
    check("raw_raddr_a_c3", w_raddr_a, 8);
    step();
    w_wb_en = 1'b0;
    settle();
    check("raw_stall_c4", w_stall, 0);
    check("raw_issue_c4", w_issue, 1);
    check("raw_raddr_a_c4", w_raddr_a, 8);
    check("raw_busy_c4", w_busy_any, 0);

    // Register 0 never tracked
    issue_wr(5'd0);
    settle();
    check("r0_issue", w_issue, 1);
    step();
    idle();
    w_dec_valid = 1'b1; w_rs = 5'd0; w_rs_used = 1'b1;
    w_wb_en = 1'b1; w_wb_addr = 5'd0;
    settle();
    check("r0_stall", w_stall, 0);
    check("r0_busy", w_busy_any, 0);
    step();
    w_wb_en = 1'b0;
    settle();
    check("r0_err", w_err, 0);

    // Saturation on r12
    for (int i = 0; i < 3; i++) begin
      issue_wr(5'd12);
      settle();
      check("sat_issue", w_issue, 1);
      step();
    end
    issue_wr(5'd12);
    settle();
    check("sat_stall4", w_stall, 1);
    check("sat_noissue4", w_issue, 0);
    step();
    check("sat_stall4_hold", w_stall, 1);
    w_wb_en = 1'b1; w_wb_addr = 5'd12;
    settle();
    check("sat_stall_wbcycle", w_stall, 1);
    step();
    w_wb_en = 1'b0;
    settle();
    check("sat_issue_after_wb", w_issue, 1);
    step();
    settle();
    check("sat_full_again", w_stall, 1);
    idle();
    w_wb_en = 1'b1; w_wb_addr = 5'd12;
    step();
    step();
    step();
    w_wb_en = 1'b0;
    settle();
    check("sat_drained_busy", w_busy_any, 0);
    check("sat_err", w_err, 0);

    // Simultaneous inc/dec on r9
    issue_wr(5'd9);
    step();
    issue_wr(5'd9);
    w_wb_en = 1'b1; w_wb_addr = 5'd9;
    settle();
    check("sim_issue", w_issue, 1);
    step();
    idle();
    w_dec_valid = 1'b1; w_rs = 5'd9; w_rs_used = 1'b1;
    settle();
    check("sim_stall", w_stall, 1);
    check("sim_busy", w_busy_any, 1);
    w_wb_en = 1'b1; w_wb_addr = 5'd9;
    step();
    w_wb_en = 1'b0;
    settle();
    check("sim_release", w_stall, 0);
    check("sim_busy_clear", w_busy_any, 0);
    check("sim_err", w_err, 0);

    // Underflow on r20, sticky
    idle();
    w_wb_en = 1'b1; w_wb_addr = 5'd20;
    settle();
    check("uf_err_same_cycle", w_err, 0);
    step();
    w_wb_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("uf_err_sticky", w_err, 1);
      step();
    end

    // Reset mid-operation with r4 holding two writes
    issue_wr(5'd4);
    step();
    step();
    idle();
    w_dec_valid = 1'b1; w_rs = 5'd4; w_rs_used = 1'b1;
    settle();
    check("mid_stall_pre", w_stall, 1);
    check("mid_busy_pre", w_busy_any, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    check("mid_busy_post", w_busy_any, 0);
    check("mid_err_post", w_err, 0);
    check("mid_stall_post", w_stall, 0);
    check("mid_issue_post", w_issue, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
